prco_decoder: RTL

Instruction decode and writeback sequencer for the PRCO core. It sits between fetch and the 8x16-bit register set. It accepts one 16-bit instruction per handshake and drives the register-set read selects with a one-cycle decode strobe. It then waits for the ALU or RAM result, issues the register write (`we`/`seld`/`datd`), and returns a done pulse to fetch.

---
 rtl/prco_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/prco_decoder.sv
// PRCO instruction decode and writeback sequencer: accepts one instruction from fetch,
// strobes the register-set read selects, waits for ALU/RAM and issues the register write.
module prco_decoder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic [15:0] i_instr,
  output logic [2:0]  q_sela,
  output logic [2:0]  q_selb,
  output logic        q_ce_dec,
  output logic [4:0]  q_opcode,
  output logic [7:0]  q_imm8,
  input  logic        i_alu_valid,
  input  logic [15:0] i_alu_result,
  input  logic        i_ram_valid,
  input  logic [15:0] i_ram_data,
  output logic        q_we,
  output logic [2:0]  q_seld,
  output logic [15:0] q_datd,
  output logic        q_busy,
  output logic        q_done,
  output logic        q_err
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_MOVI = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_SUB  = 5'h03;
  localparam logic [4:0] OP_CMP  = 5'h04;
  localparam logic [4:0] OP_LDW  = 5'h05;
  localparam logic [4:0] OP_STW  = 5'h06;

  // Counter value seen on the last WAIT cycle that may still accept a result.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sela_q, sela_d;
  logic [2:0]  selb_q, selb_d;
  logic        ce_dec_q, ce_dec_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [7:0]  imm8_q, imm8_d;
  logic        we_q, we_d;
  logic [2:0]  seld_q, seld_d;
  logic [15:0] datd_q, datd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [4:0] in_op;
  logic [4:0] cur_op;
  logic [2:0] cur_rd;
  logic       in_illegal;
  logic       cur_alu_op;
  logic       cur_writes;
  logic       result_valid;
  logic [15:0] result_data;

  assign in_op      = i_instr[15:11];
  assign in_illegal = (in_op > OP_STW);
  assign cur_op     = instr_q[15:11];
  assign cur_rd     = instr_q[10:8];
  assign cur_alu_op = (cur_op == OP_ADD) || (cur_op == OP_SUB) || (cur_op == OP_CMP);
  assign cur_writes = (cur_op == OP_ADD) || (cur_op == OP_SUB) || (cur_op == OP_LDW);

  // Only the unit that owns the current opcode may complete it; the other valid is ignored.
  assign result_valid = cur_alu_op ? i_alu_valid  : i_ram_valid;
  assign result_data  = cur_alu_op ? i_alu_result : i_ram_data;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    sela_d   = sela_q;
    selb_d   = selb_q;
    opcode_d = opcode_q;
    imm8_d   = imm8_q;
    seld_d   = seld_q;
    datd_d   = datd_q;
    ce_dec_d = 1'b0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_ce) begin
          // Outputs are registered, so the decode strobe and the NOP/illegal completion
          // are set up here to appear during the DECODE cycle itself.
          instr_d  = i_instr;
          state_d  = S_DECODE;
          ce_dec_d = 1'b1;
          sela_d   = i_instr[7:5];
          selb_d   = i_instr[4:2];
          opcode_d = in_op;
          imm8_d   = i_instr[7:0];
          if ((in_op == OP_NOP) || in_illegal) begin
            done_d = 1'b1;
            err_d  = in_illegal;
          end
        end
      end

      S_DECODE: begin
        case (cur_op)
          OP_MOVI: begin
            state_d = S_WB;
            we_d    = 1'b1;
            done_d  = 1'b1;
            seld_d  = cur_rd;
            datd_d  = {8'h00, instr_q[7:0]};
          end
          OP_ADD, OP_SUB, OP_CMP, OP_LDW, OP_STW: begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_WAIT: begin
        if (result_valid) begin
          done_d = 1'b1;
          if (cur_writes) begin
            state_d = S_WB;
            we_d    = 1'b1;
            seld_d  = cur_rd;
            datd_d  = result_data;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      instr_q  <= 16'h0000;
      cnt_q    <= 8'd0;
      sela_q   <= 3'd0;
      selb_q   <= 3'd0;
      ce_dec_q <= 1'b0;
      opcode_q <= 5'd0;
      imm8_q   <= 8'd0;
      we_q     <= 1'b0;
      seld_q   <= 3'd0;
      datd_q   <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      sela_q   <= sela_d;
      selb_q   <= selb_d;
      ce_dec_q <= ce_dec_d;
      opcode_q <= opcode_d;
      imm8_q   <= imm8_d;
      we_q     <= we_d;
      seld_q   <= seld_d;
      datd_q   <= datd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign q_sela   = sela_q;
  assign q_selb   = selb_q;
  assign q_ce_dec = ce_dec_q;
  assign q_opcode = opcode_q;
  assign q_imm8   = imm8_q;
  assign q_we     = we_q;
  assign q_seld   = seld_q;
  assign q_datd   = datd_q;
  assign q_busy   = busy_q;
  assign q_done   = done_q;
  assign q_err    = err_q;

endmodule
